// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative HI/LO multiply/divide unit (shift-add multiply, restoring divide, MTHI/MTLO).
// Optional macro MDU_FAST_MUL_EN replaces the 32-cycle multiply with a single-cycle product.
`default_nettype none

module mul_div_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            req_valid,
    input  logic [2:0]      req_op,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    input  logic            flush,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo,
    output logic            mul_div_stall,
    output logic            busy
);
    localparam logic [2:0] OP_MTHI = 3'd4;
    localparam logic [2:0] OP_MTLO = 3'd5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MUL_RUN = 2'd1,
        DIV_RUN = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [4:0]          cnt_q, cnt_d;
    logic [2*XLEN-1:0]   work_q, work_d;
    logic [XLEN-1:0]     opnd_q, opnd_d;
    logic [XLEN-1:0]     a_q, a_d;
    logic                neg_q, neg_d, rneg_q, rneg_d, dz_q, dz_d;
    logic [XLEN-1:0]     hi_q, hi_d, lo_q, lo_d;

    logic                is_md, is_signed;
    logic [XLEN-1:0]     mag_a, mag_b;
    logic [XLEN:0]       mul_sum, div_shift, div_trial;
    logic [2*XLEN-1:0]   mul_next, div_next, mul_res;
    logic [XLEN-1:0]     quo, rem;

    assign is_md     = ~req_op[2];
    assign is_signed = ~req_op[0];
    assign mag_a     = (is_signed && req_a[XLEN-1]) ? -req_a : req_a;
    assign mag_b     = (is_signed && req_b[XLEN-1]) ? -req_b : req_b;

    // Multiply: work = {partial product high half, remaining multiplier bits}.
    assign mul_sum  = {1'b0, work_q[2*XLEN-1:XLEN]} + {1'b0, (work_q[0] ? opnd_q : {XLEN{1'b0}})};
    assign mul_next = {mul_sum, work_q[XLEN-1:1]};
    assign mul_res  = neg_q ? -mul_next : mul_next;

    // Divide: work = {partial remainder, dividend bits being shifted out / quotient bits in}.
    assign div_shift = work_q[2*XLEN-1:XLEN-1];
    assign div_trial = div_shift - {1'b0, opnd_q};
    assign div_next  = div_trial[XLEN] ? {div_shift[XLEN-1:0], work_q[XLEN-2:0], 1'b0}
                                       : {div_trial[XLEN-1:0], work_q[XLEN-2:0], 1'b1};
    assign quo = neg_q  ? -div_next[XLEN-1:0]      : div_next[XLEN-1:0];
    assign rem = rneg_q ? -div_next[2*XLEN-1:XLEN] : div_next[2*XLEN-1:XLEN];

`ifdef MDU_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_mag, fast_prod;
    assign fast_mag  = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
    assign fast_prod = (is_signed && (req_a[XLEN-1] ^ req_b[XLEN-1])) ? -fast_mag : fast_mag;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        opnd_d  = opnd_q;
        a_d     = a_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        dz_d    = dz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid && is_md) begin
                        cnt_d  = 5'd0;
                        a_d    = req_a;
                        dz_d   = (req_b == {XLEN{1'b0}});
                        neg_d  = is_signed && (req_a[XLEN-1] ^ req_b[XLEN-1]);
                        rneg_d = is_signed && req_a[XLEN-1];
                        if (req_op[1]) begin
                            work_d  = {{XLEN{1'b0}}, mag_a};
                            opnd_d  = mag_b;
                            state_d = DIV_RUN;
                        end else begin
`ifdef MDU_FAST_MUL_EN
                            {hi_d, lo_d} = fast_prod;
                            state_d      = DONE;
`else
                            work_d  = {{XLEN{1'b0}}, mag_b};
                            opnd_d  = mag_a;
                            state_d = MUL_RUN;
`endif
                        end
                    end else if (req_valid && req_op == OP_MTHI) begin
                        hi_d = req_a;
                    end else if (req_valid && req_op == OP_MTLO) begin
                        lo_d = req_a;
                    end
                end
                MUL_RUN: begin
                    work_d = mul_next;
                    cnt_d  = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        {hi_d, lo_d} = mul_res;
                        state_d      = DONE;
                    end
                end
                DIV_RUN: begin
                    work_d = div_next;
                    cnt_d  = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        // Divide by zero returns all-ones quotient and the raw dividend.
                        hi_d    = dz_q ? a_q : rem;
                        lo_d    = dz_q ? {XLEN{1'b1}} : quo;
                        state_d = DONE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= 5'd0;
            work_q  <= '0;
            opnd_q  <= '0;
            a_q     <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
            opnd_q  <= opnd_d;
            a_q     <= a_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            dz_q    <= dz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign hi            = hi_q;
    assign lo            = lo_q;
    assign busy          = (state_q != IDLE);
    assign mul_div_stall = req_valid && is_md && (state_q != DONE);

endmodule

`default_nettype wire

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: randomized scoreboard bench for mul_div_unit against an arithmetic reference model.
`default_nettype none

module tb_mul_div_unit;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        req_valid = 1'b0;
    logic [2:0]  req_op = 3'd0;
    logic [31:0] req_a = '0;
    logic [31:0] req_b = '0;
    logic        flush = 1'b0;
    logic [31:0] hi, lo;
    logic        mul_div_stall, busy;

    mul_div_unit #(.XLEN(32)) dut (
        .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .flush(flush), .hi(hi), .lo(lo),
        .mul_div_stall(mul_div_stall), .busy(busy)
    );

    always #5 clk = ~clk;

`ifdef MDU_FAST_MUL_EN
    localparam int MUL_STALL = 1;
`else
    localparam int MUL_STALL = 33;
`endif

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          stall;
    } exp_t;

    exp_t        sb_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [63:0] model = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: returns the {HI,LO} pair produced by an operation given current {HI,LO}.
    function automatic logic [63:0] ref_op(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [63:0] cur);
        longint      sp;
        int          sa, sb;
        logic [63:0] r;
        sa = $signed(a);
        sb = $signed(b);
        case (op)
            3'd0: begin sp = longint'(sa) * longint'(sb); r = 64'(sp); end
            3'd1: r = {32'b0, a} * {32'b0, b};
            3'd2: begin
                if (b == 0)                                   r = {a, 32'hFFFFFFFF};
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = {32'h0, 32'h80000000};
                else                                          r = {32'(sa % sb), 32'(sa / sb)};
            end
            3'd3: r = (b == 0) ? {a, 32'hFFFFFFFF} : {a % b, a / b};
            3'd4: r = {a, cur[31:0]};
            3'd5: r = {cur[63:32], a};
            default: r = cur;
        endcase
        return r;
    endfunction

    // Monitor: pops an expectation on every completed multiply/divide (DONE cycle) and
    // one cycle after every accepted MTHI/MTLO.
    initial begin
        int   stall_run = 0;
        logic mt_pend = 1'b0;
        int   mt_stall = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!resetn || flush) begin
                stall_run = 0;
                mt_pend   = 1'b0;
            end else begin
                if (mul_div_stall) stall_run++;
                if (mt_pend) begin
                    mt_pend = 1'b0;
                    if (sb_q.size() == 0) begin
                        check("unexpected_mt", 64'd1, 64'd0);
                    end else begin
                        e = sb_q.pop_front();
                        check("mt_hilo", {hi, lo}, {e.hi, e.lo});
                        check("mt_stall", 64'(mt_stall), 64'(e.stall));
                    end
                end
                if (req_valid && (req_op == 3'd4 || req_op == 3'd5) && !busy) begin
                    mt_pend   = 1'b1;
                    mt_stall  = stall_run;
                    stall_run = 0;
                end
                if (req_valid && req_op <= 3'd3 && busy && !mul_div_stall) begin
                    if (sb_q.size() == 0) begin
                        check("unexpected_done", 64'd1, 64'd0);
                    end else begin
                        e = sb_q.pop_front();
                        check("md_hilo", {hi, lo}, {e.hi, e.lo});
                        check("md_stall", 64'(stall_run), 64'(e.stall));
                    end
                    stall_run = 0;
                end
            end
        end
    end

    task automatic run_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int   cyc = 0;
        model   = ref_op(op, a, b, model);
        e.hi    = model[63:32];
        e.lo    = model[31:0];
        e.stall = (op <= 3'd1) ? MUL_STALL : 33;
        sb_q.push_back(e);
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
        do begin
            @(posedge clk); #1;
            cyc++;
        end while (!(busy && !mul_div_stall) && cyc < 100);
        if (cyc >= 100) check("md_timeout", 64'(cyc), 64'd0);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic run_mt(input logic [2:0] op, input logic [31:0] a);
        exp_t e;
        model   = ref_op(op, a, 32'h0, model);
        e.hi    = model[63:32];
        e.lo    = model[31:0];
        e.stall = 0;
        sb_q.push_back(e);
        req_valid = 1'b1; req_op = op; req_a = a; req_b = $urandom;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  op;
        logic [31:0] a, b;
        // Reset state, and stall is still combinational while held in reset.
        #3;
        check("rst_hilo", {hi, lo}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        req_valid = 1'b1; req_op = 3'd0;
        #1;
        check("rst_stall_req", {63'd0, mul_div_stall}, 64'd1);
        req_valid = 1'b0;
        #1;
        check("rst_stall_idle", {63'd0, mul_div_stall}, 64'd0);
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;

        // Directed vectors.
        run_md(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
        run_md(3'd0, 32'hFFFFFFFE, 32'd3);
        run_md(3'd2, 32'hFFFFFFF9, 32'd2);
        run_md(3'd3, 32'h00001234, 32'd0);
        run_md(3'd2, 32'h80000000, 32'hFFFFFFFF);
        run_md(3'd2, 32'hFFFFFFF9, 32'd0);
        run_mt(3'd4, 32'hDEADBEEF);
        run_mt(3'd5, 32'h0BADF00D);
        @(posedge clk); #1;

        // Reserved opcode and MTHI under flush must leave HI/LO alone.
        req_valid = 1'b1; req_op = 3'd6; req_a = 32'h11111111;
        @(posedge clk); #1;
        req_op = 3'd4; flush = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0; flush = 1'b0;
        check("ignored_ops_hilo", {hi, lo}, model);
        check("ignored_ops_busy", {63'd0, busy}, 64'd0);

        // Randomized mix with occasional zero divisors and the overflow pair.
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 5));
            a  = $urandom;
            b  = $urandom;
            if ($urandom_range(0, 7) == 0) b = 32'h0;
            if (op == 3'd2 && $urandom_range(0, 7) == 0) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
            if ($urandom_range(0, 3) == 0) a = a >> $urandom_range(0, 31);
            if (op <= 3'd3) run_md(op, a, b);
            else            run_mt(op, a);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        // Flush on the 10th DIV_RUN cycle, then a normal request.
        req_valid = 1'b1; req_op = 3'd3; req_a = $urandom; req_b = 32'd7;
        @(posedge clk); #1;
        repeat (9) @(posedge clk);
        #1;
        check("flush_busy_before", {63'd0, busy}, 64'd1);
        flush = 1'b1; req_valid = 1'b0;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_busy_after", {63'd0, busy}, 64'd0);
        check("flush_hilo", {hi, lo}, model);
        run_md(3'd3, 32'd100, 32'd7);

        // Asynchronous reset in the middle of an operation.
`ifdef MDU_FAST_MUL_EN
        req_valid = 1'b1; req_op = 3'd3; req_a = $urandom; req_b = $urandom;
`else
        req_valid = 1'b1; req_op = 3'd1; req_a = $urandom; req_b = $urandom;
`endif
        repeat (6) @(posedge clk);
        #1;
        check("mid_busy", {63'd0, busy}, 64'd1);
        resetn = 1'b0;
        #1;
        model = '0;
        check("async_rst_hilo", {hi, lo}, model);
        check("async_rst_busy", {63'd0, busy}, 64'd0);
        req_valid = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;
        run_md(3'd0, 32'h7FFFFFFF, 32'h80000000);

        repeat (3) @(posedge clk);
        #1;
        check("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
